// File: rtl/traffic_pkg.sv
// Shared encodings for the light sequencer: phases, timer states, phase successor.
package traffic_pkg;
   localparam int CW = 4;

   localparam logic [1:0] PH_0 = 2'b00;
   localparam logic [1:0] PH_1 = 2'b01;
   localparam logic [1:0] PH_2 = 2'b10;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_HOLD = 2'd1,
      S_SYNC = 2'd2
   } state_t;

   // The unused phase code 2'b11 behaves as PH_0, so its successor is PH_1.
   function automatic logic [1:0] nxt(input logic [1:0] p);
      unique case (p)
         PH_0:    nxt = PH_1;
         PH_1:    nxt = PH_2;
         PH_2:    nxt = PH_0;
         default: nxt = PH_1;
      endcase
   endfunction
endpackage

// File: rtl/phase_timer_if.sv
// Phase timer <-> light FSM signal bundle; master is the FSM side.
interface phase_timer_if import traffic_pkg::*; #(
   parameter int RW = 8
) ();
   logic [1:0]    phase;
   logic          pause;
   logic [CW-1:0] count;
   logic          expired;
   logic          resync;
   logic          paused;
   logic [RW-1:0] round_cnt;

   modport master (
      output phase, pause,
      input  count, expired, resync, paused, round_cnt
   );

   modport slave (
      input  phase, pause,
      output count, expired, resync, paused, round_cnt
   );
endinterface

// File: rtl/phase_timer_dur_lut.sv
// Phase -> reload duration lookup; 2'b11 falls back to the phase-0 duration.
module dur_lut import traffic_pkg::*; #(
   parameter int DUR0 = 5,
   parameter int DUR1 = 2,
   parameter int DUR2 = 3
) (
   input  logic [1:0]    phase,
   output logic [CW-1:0] dur
);
   always_comb begin
      dur = CW'(DUR0);
      unique case (phase)
         PH_1:    dur = CW'(DUR1);
         PH_2:    dur = CW'(DUR2);
         default: dur = CW'(DUR0);
      endcase
   end
endmodule

// File: rtl/phase_timer.sv
// Per-phase countdown for the light FSM with pause, desync recovery and round counting.
module phase_timer import traffic_pkg::*; #(
   parameter int DUR0 = 5,
   parameter int DUR1 = 2,
   parameter int DUR2 = 3,
   parameter int RW   = 8
) (
   input  logic         clock_div,
   input  logic         reset,
   phase_timer_if.slave bus
);
   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    exp_q, exp_d;
   logic          resync_q, resync_d;
   logic [RW-1:0] round_q, round_d;

   logic [CW-1:0] dur_cur, dur_nxt;
   logic [1:0]    nxt_ph;
   logic          mismatch;

   assign nxt_ph = nxt(bus.phase);

   dur_lut #(.DUR0(DUR0), .DUR1(DUR1), .DUR2(DUR2)) u_dur_cur (
      .phase (bus.phase),
      .dur   (dur_cur)
   );

   dur_lut #(.DUR0(DUR0), .DUR1(DUR1), .DUR2(DUR2)) u_dur_nxt (
      .phase (nxt_ph),
      .dur   (dur_nxt)
   );

   // A phase change is only legitimate on the expiry edge; anything else is a desync.
   assign mismatch = (bus.phase != exp_q) && ((count_q != '0) || (state_q != S_RUN));

   always_ff @(posedge clock_div or negedge reset) begin
      if (!reset) begin
         state_q  <= S_RUN;
         count_q  <= CW'(DUR0);
         exp_q    <= PH_0;
         resync_q <= 1'b0;
         round_q  <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         exp_q    <= exp_d;
         resync_q <= resync_d;
         round_q  <= round_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      exp_d    = exp_q;
      resync_d = 1'b0;
      round_d  = round_q;
      if (mismatch) begin
         count_d  = dur_cur;
         exp_d    = bus.phase;
         resync_d = 1'b1;
         state_d  = S_SYNC;
      end else begin
         unique case (state_q)
            S_RUN: begin
               // Pause outranks expiry so the FSM never advances while held.
               if (bus.pause) begin
                  state_d = S_HOLD;
               end else if (count_q == '0) begin
                  count_d = dur_nxt;
                  exp_d   = nxt_ph;
                  if (bus.phase == PH_2) round_d = round_q + RW'(1);
               end else begin
                  count_d = count_q - CW'(1);
               end
            end
            S_HOLD:  if (!bus.pause) state_d = S_RUN;
            S_SYNC:  state_d = bus.pause ? S_HOLD : S_RUN;
            default: state_d = S_RUN;
         endcase
      end
   end

   assign bus.count     = count_q;
   assign bus.expired   = (state_q == S_RUN) && (count_q == '0);
   assign bus.resync    = resync_q;
   assign bus.paused    = (state_q == S_HOLD);
   assign bus.round_cnt = round_q;
endmodule

// File: tb/tb_phase_timer.sv
// Phase timer bench: directed scenarios then random pause/phase forcing against a reference model.
module tb_phase_timer;
   logic clock_div = 1'b0;
   logic reset     = 1'b0;

   phase_timer_if #(.RW(8)) bus  ();
   phase_timer_if #(.RW(2)) bus2 ();

   phase_timer #(.DUR0(5), .DUR1(2), .DUR2(3), .RW(8)) u_dut (
      .clock_div (clock_div),
      .reset     (reset),
      .bus       (bus.slave)
   );

   phase_timer #(.DUR0(5), .DUR1(2), .DUR2(3), .RW(2)) u_dut2 (
      .clock_div (clock_div),
      .reset     (reset),
      .bus       (bus2.slave)
   );

   always #5 clock_div = ~clock_div;

   // Reference model: durations and successor as tables indexed by phase code.
   int dur_tbl [4] = '{5, 2, 3, 5};
   int nxt_tbl [4] = '{1, 2, 0, 1};
   int m_count, m_mode, m_exp, m_rounds, fsm_ph;  // m_mode: 0 run, 1 hold, 2 sync
   bit m_resync;
   int n_total = 0, n_pass = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("count",    32'(bus.count),     32'(m_count));
      chk("expired",  32'(bus.expired),   32'(m_mode == 0 && m_count == 0));
      chk("resync",   32'(bus.resync),    32'(m_resync));
      chk("paused",   32'(bus.paused),    32'(m_mode == 1));
      chk("round8",   32'(bus.round_cnt), 32'(m_rounds % 256));
      chk("round2",   32'(bus2.round_cnt), 32'(m_rounds % 4));
      chk("count_b",  32'(bus2.count),    32'(m_count));
   endtask

   task automatic model_reset();
      m_count = 5; m_mode = 0; m_exp = 0; m_rounds = 0; m_resync = 0; fsm_ph = 0;
   endtask

   task automatic model_step(input int ph, input bit pa);
      bit desync;
      desync = (ph != m_exp) && (m_count != 0 || m_mode != 0);
      m_resync = 0;
      if (desync) begin
         m_count = dur_tbl[ph]; m_exp = ph; m_resync = 1; m_mode = 2;
      end else if (m_mode == 0) begin
         if (pa) m_mode = 1;
         else if (m_count == 0) begin
            if (ph == 2) m_rounds++;
            m_exp   = nxt_tbl[ph];
            m_count = dur_tbl[m_exp];
            fsm_ph  = m_exp;
         end else m_count--;
      end else if (m_mode == 1) begin
         if (!pa) m_mode = 0;
      end else begin
         m_mode = pa ? 1 : 0;
      end
   endtask

   task automatic tick(input int ph, input bit pa);
      bus.phase = 2'(ph);  bus.pause = pa;
      bus2.phase = 2'(ph); bus2.pause = pa;
      fsm_ph = ph;
      model_step(ph, pa);
      @(posedge clock_div);
      #1;
      check_outputs();
   endtask

   task automatic run_until(input int ph, input int cnt);
      bit ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (fsm_ph == ph && m_count == cnt && m_mode == 0) begin ok = 1; break; end
         tick(fsm_ph, 1'b0);
      end
      chk("run_until", 32'(ok), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc, ph;
      bit pa;
      model_reset();
      bus.phase = 2'b00;  bus.pause = 1'b0;
      bus2.phase = 2'b00; bus2.pause = 1'b0;
      #12;
      check_outputs();
      reset = 1'b1;

      // Free run long enough for five rounds; narrow counter reads 1 after wrap.
      repeat (70) tick(fsm_ph, 1'b0);
      chk("rounds5_wrap", 32'(bus2.round_cnt), 32'd1);
      chk("rounds5_wide", 32'(bus.round_cnt), 32'd5);

      // Pause for four ticks at count 3, then one-tick resume latency.
      run_until(0, 3);
      repeat (4) tick(0, 1'b1);
      chk("hold_count", 32'(bus.count), 32'd3);
      tick(0, 1'b0);
      chk("resume_latency", 32'(bus.count), 32'd3);
      tick(0, 1'b0);
      chk("resume_dec", 32'(bus.count), 32'd2);

      // Pause landing on count 0 blocks expiry until resume.
      run_until(0, 0);
      tick(0, 1'b1);
      chk("zero_pause_exp", 32'(bus.expired), 32'd0);
      repeat (2) tick(0, 1'b1);
      chk("zero_pause_ph", 32'(fsm_ph), 32'd0);
      tick(0, 1'b0);
      chk("zero_resume_exp", 32'(bus.expired), 32'd1);
      tick(fsm_ph, 1'b0);
      chk("zero_reload_dur1", 32'(bus.count), 32'd2);

      // Forced jump to phase 10 mid-phase 00.
      run_until(0, 4);
      rc = m_rounds;
      tick(2, 1'b0);
      chk("force_count", 32'(bus.count), 32'd3);
      chk("force_resync", 32'(bus.resync), 32'd1);
      tick(2, 1'b0);
      chk("force_resync_clr", 32'(bus.resync), 32'd0);
      chk("force_round", 32'(bus.round_cnt), 32'(rc % 256));

      // Illegal phase 11 reloads DUR0 and later hands over to phase 01.
      run_until(0, 2);
      tick(3, 1'b0);
      chk("ph3_count", 32'(bus.count), 32'd5);
      chk("ph3_resync", 32'(bus.resync), 32'd1);
      repeat (8) tick(fsm_ph, 1'b0);

      // Async reset between edges, mid-phase 01.
      run_until(1, 1);
      @(negedge clock_div);
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clock_div);
      reset = 1'b1;

      // Random pause toggling and occasional phase forcing.
      pa = 1'b0;
      repeat (300) begin
         if ($urandom_range(0, 5) == 0) pa = ~pa;
         ph = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : fsm_ph;
         tick(ph, pa);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
- Per-phase countdown timer feeding the light-sequencing FSM: produces `count`, which the FSM watches for zero to advance its 2-bit phase.
- Consumes the FSM's current phase, reloads the duration of the upcoming phase on expiry, and supports pause.
- Detects phase/timer desynchronisation and resynchronises.
- Runs in the 1 Hz `clock_div` domain produced by the frequency divider.

Parameters:
- DUR0, 5, reload value for phase 2'b00; phase lasts DUR0+1 ticks; legal 1..15.
- DUR1, 2, reload value for phase 2'b01; legal 1..15.
- DUR2, 3, reload value for phase 2'b10; legal 1..15.
- RW, 8, width of the completed-round counter.

Ports:
- clock_div  input  1  1 Hz tick clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- phase  input  2  current FSM phase; 2'b11 is illegal and treated as 2'b00.
- pause  input  1  level; holds the countdown while high.
- count  output  4  remaining ticks in the current phase; FSM advances on the edge after count==0.
- expired  output  1  high while count==0 and in S_RUN (combinational from registers).
- resync  output  1  one-tick pulse, registered: a phase mismatch was corrected on the previous edge.
- paused  output  1  high while in S_HOLD.
- round_cnt  output  RW  number of completed 00→01→10 rounds; wraps modulo 2^RW.

Behaviour:
- Reset (reset==0, async):
  - count=DUR0, state=S_RUN, exp_phase=2'b00, resync=0, round_cnt=0.
  - This matches the FSM resetting to 2'b00.
- Helper: nxt(p) = 00→01, 01→10, 10→00, 11→01 (11 is treated as 00). DUR[p] selects DUR0/1/2; p=11 selects DUR0.
- States:
  - S_RUN: normal countdown.
  - S_HOLD: paused.
  - S_SYNC: one-tick resync settle.
- Evaluation order at each posedge, highest priority first:
  1. Mismatch: phase != exp_phase, and count != 0 or the state is not S_RUN. Action: count<=DUR[phase], exp_phase<=phase, resync<=1, state<=S_SYNC. round_cnt is unchanged.
  2. S_RUN and pause==1: state<=S_HOLD; count is unchanged.
  3. S_RUN and count==0: count<=DUR[nxt(phase)], exp_phase<=nxt(phase). If phase==2'b10, round_cnt<=round_cnt+1 (wraps). The FSM advances on the same edge, so both agree on the new phase.
  4. S_RUN and count>0: count<=count-1.
  5. S_HOLD: if pause==0, state<=S_RUN; count is held for this edge (one-tick resume latency).
  6. S_SYNC: state<=S_RUN, or S_HOLD if pause==1; count is unchanged.
- resync: cleared on every edge where rule 1 does not fire.
- Pause arriving exactly when count==0:
  - Rule 2 wins. expired drops, so the FSM holds phase.
  - Expiry completes after resume, once count is observed at 0 again in S_RUN.
- No underflow: count never decrements below 0.
- Reload values are parameter constants; no runtime load port.
- Reset mid-phase: immediate return to reset values; no pending expiry survives.

Decomposition:
- Shared package (traffic_pkg): phase encodings PH_0=2'b00, PH_1=2'b01, PH_2=2'b10; state encodings S_RUN/S_HOLD/S_SYNC; nxt() function; count width constant CW=4.
- One natural sub-module, dur_lut: combinational phase→duration mux parameterised by DUR0..2. Instantiated twice, for DUR[phase] and DUR[nxt(phase)].
- Everything else lives in phase_timer.

Test Plan:
- Free run, defaults, pause=0, bench phase model follows count==0.
  - count sequence: 5,4,3,2,1,0 | 2,1,0 | 3,2,1,0 | 5…
  - expired high on each 0.
  - round_cnt 0→1 on the edge leaving phase 10.
- Pause at count==3 in phase 00 for 4 ticks.
  - count holds 3 and paused=1 throughout.
  - After release: one tick still at 3, then 2,1,0.
- Pause asserted on the same edge count reaches 0.
  - expired=0 while paused, and phase stays 00 in the model.
  - After resume: expired=1 for one tick, then count=DUR1=2.
- Force phase=2'b10 while count==4 in phase 00.
  - Next edge: count=3 (DUR2), resync=1 for exactly one tick, state S_SYNC then S_RUN.
  - round_cnt unchanged.
- Async reset asserted mid-phase 01 at count==1, between clock edges.
  - Outputs immediately: count=5, round_cnt=0, resync=0, paused=0.
- RW=2, run 5 full rounds.
  - round_cnt sequence 1,2,3,0,1 (wraps cleanly).
  - phase=2'b11 injected: reload uses DUR0, resync pulses.
